// File: rtl/multi_zone_stove.sv
// rtl/multi_zone_stove.sv - multi-zone cooktop controller: power FSM, zone selection, levels, idle auto-off, 7-seg.
// Residual-heat tracking is built only when STOVE_RESIDUAL_HEAT_EN is defined.
module multi_zone_stove #(
  parameter int ZONES        = 4,
  parameter int MAX_LEVEL    = 9,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int HEAT_HOLD    = 500
) (
  input  logic               clk,
  input  logic               async_reset,
  input  logic               power_toggle,
  input  logic [ZONES-1:0]   surface_toggle,
  input  logic               power_level_inc,
  input  logic               power_level_dec,
  output logic               power_on,
  output logic [ZONES-1:0]   selected,
  output logic [4*ZONES-1:0] power_levels,
  output logic [ZONES-1:0]   hot,
  output logic [8*ZONES-1:0] power_level_7seg_output
);
  localparam logic ST_OFF = 1'b0;
  localparam logic ST_ON  = 1'b1;
  localparam int IW = $clog2(IDLE_TIMEOUT);
  localparam logic [3:0] MAX_LVL = 4'(MAX_LEVEL);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  logic               state_q, state_d;
  logic [ZONES-1:0]   sel_q, sel_d;
  logic [4*ZONES-1:0] lvl_q, lvl_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic               any_pulse, clear_all;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    lvl_d     = lvl_q;
    idle_d    = idle_q;
    clear_all = 1'b0;
    any_pulse = power_toggle | (|surface_toggle) | power_level_inc | power_level_dec;
    if (state_q == ST_OFF) begin
      if (power_toggle) begin
        state_d   = ST_ON;
        clear_all = 1'b1;
      end
    end else if (power_toggle) begin
      state_d   = ST_OFF;
      clear_all = 1'b1;
    end else if (any_pulse) begin
      idle_d = '0;
      sel_d  = sel_q ^ surface_toggle;
      // inc/dec follow the selection as it stood before this edge
      for (int i = 0; i < ZONES; i++) begin
        if (sel_q[i] && power_level_inc && !power_level_dec && lvl_q[4*i +: 4] < MAX_LVL)
          lvl_d[4*i +: 4] = lvl_q[4*i +: 4] + 4'd1;
        if (sel_q[i] && power_level_dec && !power_level_inc && lvl_q[4*i +: 4] != 4'd0)
          lvl_d[4*i +: 4] = lvl_q[4*i +: 4] - 4'd1;
      end
    end else if (idle_q == IDLE_LAST) begin
      state_d   = ST_OFF;
      clear_all = 1'b1;
    end else begin
      idle_d = idle_q + IW'(1);
    end
    if (clear_all) begin
      sel_d  = '0;
      lvl_d  = '0;
      idle_d = '0;
    end
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      state_q <= ST_OFF;
      sel_q   <= '0;
      lvl_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      lvl_q   <= lvl_d;
      idle_q  <= idle_d;
    end
  end

`ifdef STOVE_RESIDUAL_HEAT_EN
  localparam int HW = $clog2(HEAT_HOLD + 1);
  logic [ZONES-1:0] hot_q, hot_d;
  logic [HW-1:0]    heat_q [ZONES];
  logic [HW-1:0]    heat_d [ZONES];

  always_comb begin
    hot_d = hot_q;
    for (int i = 0; i < ZONES; i++) begin
      heat_d[i] = heat_q[i];
      if (lvl_d[4*i +: 4] != 4'd0) begin
        hot_d[i]  = 1'b0;
        heat_d[i] = '0;
      end else if (lvl_q[4*i +: 4] != 4'd0) begin
        hot_d[i]  = 1'b1;
        heat_d[i] = HW'(HEAT_HOLD);
      end else if (heat_q[i] != '0) begin
        heat_d[i] = heat_q[i] - HW'(1);
        if (heat_q[i] == HW'(1)) hot_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      hot_q <= '0;
      for (int i = 0; i < ZONES; i++) heat_q[i] <= '0;
    end else begin
      hot_q <= hot_d;
      for (int i = 0; i < ZONES; i++) heat_q[i] <= heat_d[i];
    end
  end

  assign hot = hot_q;
`else
  // HEAT_HOLD is at least 1, so this is constant zero
  assign hot = {ZONES{HEAT_HOLD < 1}};
`endif

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  always_comb begin
    power_level_7seg_output = '1;
    for (int i = 0; i < ZONES; i++) begin
      if (state_q == ST_OFF)
        power_level_7seg_output[8*i +: 8] = hot[i] ? 8'h89 : 8'hFF;
      else
        power_level_7seg_output[8*i +: 8] = {~sel_q[i],
          (hot[i] && lvl_q[4*i +: 4] == 4'd0) ? 7'h09 : seg_code(lvl_q[4*i +: 4])};
    end
  end

  assign power_on     = state_q;
  assign selected     = sel_q;
  assign power_levels = lvl_q;
endmodule

// File: tb/tb_multi_zone_stove.sv
// tb/tb_multi_zone_stove.sv - self-checking bench for multi_zone_stove against a behavioural model.
module tb_multi_zone_stove;
  localparam int Z  = 3;
  localparam int ML = 9;
  localparam int TO = 8;
  localparam int HH = 4;

  logic           clk = 1'b0;
  logic           async_reset;
  logic           power_toggle;
  logic [Z-1:0]   surface_toggle;
  logic           power_level_inc;
  logic           power_level_dec;
  logic           power_on;
  logic [Z-1:0]   selected;
  logic [4*Z-1:0] power_levels;
  logic [Z-1:0]   hot;
  logic [8*Z-1:0] power_level_7seg_output;

  int vectors = 0;
  int miscompares = 0;

  bit m_on;
  int m_idle;
  int m_lvl [Z];
  bit m_sel [Z];
  bit m_hot [Z];
  int m_cnt [Z];
  logic [6:0] digit_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  multi_zone_stove #(.ZONES(Z), .MAX_LEVEL(ML), .IDLE_TIMEOUT(TO), .HEAT_HOLD(HH)) dut (
    .clk(clk),
    .async_reset(async_reset),
    .power_toggle(power_toggle),
    .surface_toggle(surface_toggle),
    .power_level_inc(power_level_inc),
    .power_level_dec(power_level_dec),
    .power_on(power_on),
    .selected(selected),
    .power_levels(power_levels),
    .hot(hot),
    .power_level_7seg_output(power_level_7seg_output)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_on = 0;
    m_idle = 0;
    for (int z = 0; z < Z; z++) begin
      m_lvl[z] = 0; m_sel[z] = 0; m_hot[z] = 0; m_cnt[z] = 0;
    end
  endtask

  task automatic model_step(input bit pt, input logic [Z-1:0] st, input bit up, input bit dn);
    int old [Z];
    bit clr;
    bit pulse;
    clr = 0;
    pulse = pt || (st != 0) || up || dn;
    for (int z = 0; z < Z; z++) old[z] = m_lvl[z];
    if (!m_on) begin
      if (pt) begin m_on = 1; clr = 1; end
    end else if (pt) begin
      m_on = 0; clr = 1;
    end else if (pulse) begin
      m_idle = 0;
      for (int z = 0; z < Z; z++) begin
        if (m_sel[z] && up && !dn && m_lvl[z] < ML) m_lvl[z] = m_lvl[z] + 1;
        if (m_sel[z] && dn && !up && m_lvl[z] > 0) m_lvl[z] = m_lvl[z] - 1;
        if (st[z]) m_sel[z] = !m_sel[z];
      end
    end else begin
      m_idle = m_idle + 1;
      if (m_idle == TO) begin m_on = 0; clr = 1; end
    end
    if (clr) begin
      m_idle = 0;
      for (int z = 0; z < Z; z++) begin m_sel[z] = 0; m_lvl[z] = 0; end
    end
`ifdef STOVE_RESIDUAL_HEAT_EN
    for (int z = 0; z < Z; z++) begin
      if (m_lvl[z] != 0) begin
        m_cnt[z] = 0;
      end else if (old[z] != 0) begin
        m_cnt[z] = HH;
      end else if (m_cnt[z] > 0) begin
        m_cnt[z] = m_cnt[z] - 1;
      end
      m_hot[z] = (m_cnt[z] > 0);
    end
`endif
  endtask

  function automatic logic [4*Z-1:0] exp_levels();
    logic [4*Z-1:0] v;
    for (int z = 0; z < Z; z++) v[4*z +: 4] = 4'(m_lvl[z]);
    return v;
  endfunction

  function automatic logic [Z-1:0] exp_sel();
    logic [Z-1:0] v;
    for (int z = 0; z < Z; z++) v[z] = m_sel[z];
    return v;
  endfunction

  function automatic logic [Z-1:0] exp_hot();
    logic [Z-1:0] v;
    for (int z = 0; z < Z; z++) v[z] = m_hot[z];
    return v;
  endfunction

  function automatic logic [8*Z-1:0] exp_seg();
    logic [8*Z-1:0] v;
    for (int z = 0; z < Z; z++) begin
      if (!m_on) v[8*z +: 8] = m_hot[z] ? 8'h89 : 8'hFF;
      else v[8*z +: 8] = {!m_sel[z], (m_lvl[z] == 0 && m_hot[z]) ? 7'h09 : digit_tab[m_lvl[z]]};
    end
    return v;
  endfunction

  // Called at a falling edge; returns at the next falling edge with the model advanced.
  task automatic apply(input bit pt, input logic [Z-1:0] st, input bit up, input bit dn);
    power_toggle = pt; surface_toggle = st; power_level_inc = up; power_level_dec = dn;
    @(posedge clk);
    model_step(pt, st, up, dn);
    #1;
    power_toggle = 0; surface_toggle = '0; power_level_inc = 0; power_level_dec = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    async_reset = 0; power_toggle = 0; surface_toggle = '0; power_level_inc = 0; power_level_dec = 0;
    model_reset();
    #1;
    vectors++; if (power_on !== 1'b0) begin miscompares++; $display("FAIL reset_power_on: got %b expected 0", power_on); end
    vectors++; if (selected !== '0) begin miscompares++; $display("FAIL reset_selected: got %b expected 0", selected); end
    vectors++; if (power_levels !== '0) begin miscompares++; $display("FAIL reset_levels: got %h expected 0", power_levels); end
    vectors++; if (hot !== '0) begin miscompares++; $display("FAIL reset_hot: got %b expected 0", hot); end
    vectors++; if (power_level_7seg_output !== {Z{8'hFF}}) begin miscompares++; $display("FAIL reset_7seg: got %h expected %h", power_level_7seg_output, {Z{8'hFF}}); end
    @(negedge clk);
    async_reset = 1;
    @(negedge clk);
    vectors++; if (power_on !== 1'b0) begin miscompares++; $display("FAIL reset_release_off: got %b expected 0", power_on); end
  endtask

  task automatic test_power_on();
    apply(1, '0, 0, 0);
    vectors++; if (power_on !== 1'b1) begin miscompares++; $display("FAIL pon_power_on: got %b expected 1", power_on); end
    vectors++; if (selected !== '0 || power_levels !== '0) begin miscompares++; $display("FAIL pon_clear: got sel %b lvl %h expected 0/0", selected, power_levels); end
    vectors++; if (power_level_7seg_output !== {Z{8'hC0}}) begin miscompares++; $display("FAIL pon_7seg: got %h expected %h", power_level_7seg_output, {Z{8'hC0}}); end
  endtask

  task automatic test_saturation();
    apply(0, 3'b001, 0, 0);
    repeat (10) apply(0, '0, 1, 0);
    vectors++; if (power_levels[3:0] !== 4'd9) begin miscompares++; $display("FAIL sat_level0: got %0d expected 9", power_levels[3:0]); end
    vectors++; if (power_levels[7:4] !== 4'd0) begin miscompares++; $display("FAIL sat_level1: got %0d expected 0", power_levels[7:4]); end
    vectors++; if (power_level_7seg_output[7:0] !== 8'h10) begin miscompares++; $display("FAIL sat_byte0: got %h expected 10", power_level_7seg_output[7:0]); end
  endtask

  task automatic test_inc_dec_same();
    apply(1, '0, 0, 0);
    apply(1, '0, 0, 0);
    apply(0, 3'b001, 0, 0);
    repeat (3) apply(0, '0, 1, 0);
    apply(0, 3'b010, 0, 0);
    apply(0, '0, 1, 1);
    vectors++; if (power_levels !== 12'h003) begin miscompares++; $display("FAIL incdec_same: got %h expected 003", power_levels); end
    apply(0, '0, 0, 1);
    vectors++; if (power_levels !== 12'h002) begin miscompares++; $display("FAIL incdec_dec: got %h expected 002", power_levels); end
    apply(0, 3'b100, 1, 0);
    vectors++; if (power_levels !== 12'h013) begin miscompares++; $display("FAIL incdec_old_sel: got %h expected 013", power_levels); end
    vectors++; if (selected !== 3'b111) begin miscompares++; $display("FAIL incdec_sel: got %b expected 111", selected); end
  endtask

  task automatic test_idle_timeout();
    apply(1, '0, 0, 0);
    apply(1, '0, 0, 0);
    repeat (TO - 1) apply(0, '0, 0, 0);
    vectors++; if (power_on !== 1'b1) begin miscompares++; $display("FAIL idle_early: got %b expected 1", power_on); end
    apply(0, '0, 0, 0);
    vectors++; if (power_on !== 1'b0) begin miscompares++; $display("FAIL idle_off: got %b expected 0", power_on); end
    apply(1, '0, 0, 0);
    repeat (4) apply(0, '0, 0, 0);
    apply(0, '0, 0, 1);
    repeat (TO - 1) apply(0, '0, 0, 0);
    vectors++; if (power_on !== 1'b1) begin miscompares++; $display("FAIL idle_delay_early: got %b expected 1", power_on); end
    apply(0, '0, 0, 0);
    vectors++; if (power_on !== 1'b0) begin miscompares++; $display("FAIL idle_delay_off: got %b expected 0", power_on); end
  endtask

  task automatic test_residual_heat();
    apply(1, '0, 0, 0);
    apply(0, 3'b001, 0, 0);
    apply(0, '0, 1, 0);
    apply(1, '0, 0, 0);
`ifdef STOVE_RESIDUAL_HEAT_EN
    for (int k = 0; k < HH; k++) begin
      vectors++; if (hot[0] !== 1'b1 || power_level_7seg_output[7:0] !== 8'h89) begin miscompares++; $display("FAIL heat_hold_%0d: got hot %b byte %h expected 1/89", k, hot[0], power_level_7seg_output[7:0]); end
      if (k < HH - 1) apply(0, '0, 0, 0);
    end
    apply(0, '0, 0, 0);
    vectors++; if (hot[0] !== 1'b0 || power_level_7seg_output[7:0] !== 8'hFF) begin miscompares++; $display("FAIL heat_expire: got hot %b byte %h expected 0/FF", hot[0], power_level_7seg_output[7:0]); end
`else
    vectors++; if (hot !== '0 || power_level_7seg_output[7:0] !== 8'hFF) begin miscompares++; $display("FAIL heat_disabled: got hot %b byte %h expected 0/FF", hot, power_level_7seg_output[7:0]); end
`endif
  endtask

  task automatic test_random();
    bit pt, up, dn;
    logic [Z-1:0] st;
    for (int n = 0; n < 600; n++) begin
      pt = ($urandom_range(0, 19) == 0);
      for (int z = 0; z < Z; z++) st[z] = ($urandom_range(0, 5) == 0);
      up = ($urandom_range(0, 2) == 0);
      dn = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin st = '0; up = 0; dn = 0; end
      apply(pt, st, up, dn);
      vectors++; if (power_on !== m_on) begin miscompares++; $display("FAIL rand_power_on[%0d]: got %b expected %b", n, power_on, m_on); end
      vectors++; if (selected !== exp_sel()) begin miscompares++; $display("FAIL rand_selected[%0d]: got %b expected %b", n, selected, exp_sel()); end
      vectors++; if (power_levels !== exp_levels()) begin miscompares++; $display("FAIL rand_levels[%0d]: got %h expected %h", n, power_levels, exp_levels()); end
      vectors++; if (hot !== exp_hot()) begin miscompares++; $display("FAIL rand_hot[%0d]: got %b expected %b", n, hot, exp_hot()); end
      vectors++; if (power_level_7seg_output !== exp_seg()) begin miscompares++; $display("FAIL rand_7seg[%0d]: got %h expected %h", n, power_level_7seg_output, exp_seg()); end
    end
  endtask

  task automatic test_reset_midop();
    if (m_on) apply(1, '0, 0, 0);
    apply(1, '0, 0, 0);
    apply(0, {Z{1'b1}}, 0, 0);
    repeat (5) apply(0, '0, 1, 0);
    vectors++; if (power_levels !== 12'h555) begin miscompares++; $display("FAIL midop_levels: got %h expected 555", power_levels); end
    #2;
    async_reset = 0;
    model_reset();
    #1;
    vectors++; if (power_on !== 1'b0 || selected !== '0 || power_levels !== '0 || hot !== '0) begin miscompares++; $display("FAIL midop_reset: got on %b sel %b lvl %h hot %b expected all 0", power_on, selected, power_levels, hot); end
    vectors++; if (power_level_7seg_output !== {Z{8'hFF}}) begin miscompares++; $display("FAIL midop_7seg: got %h expected %h", power_level_7seg_output, {Z{8'hFF}}); end
    @(negedge clk);
    async_reset = 1;
    apply(0, '0, 1, 0);
    vectors++; if (power_on !== 1'b0 || power_levels !== '0) begin miscompares++; $display("FAIL midop_release: got on %b lvl %h expected 0/0", power_on, power_levels); end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_saturation();
    test_inc_dec_same();
    test_idle_timeout();
    test_residual_heat();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
